// File: rtl/rst_seq_pkg.sv
// Shared types for the PL reset sequencer.
// State encoding and counter width helper.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } seq_state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer.
// Clears to 0 under the async-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// PL reset sequencer: stretch, then staged
// release of active-low domain resets.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS    = 4,
  parameter int STRETCH_CYCLES = 16,
  parameter int STAGE_GAP      = 8
) (
  input  logic                   pl_clk_100m,
  input  logic                   pl_rst,
  input  logic                   ext_rstn_in,
  input  logic                   lock_in,
  input  logic                   sw_rst_req,
  output logic                   sw_rst_ack,
  output logic [NUM_DOMAINS-1:0] dom_rstn,
  output logic                   seq_done,
  output logic [1:0]             seq_state
);

  localparam int SCW = cnt_w(STRETCH_CYCLES);
  localparam int GCW = cnt_w(STAGE_GAP);
  localparam int SKW = cnt_w(NUM_DOMAINS);

  localparam logic [SCW-1:0] S_TERM =
    SCW'(STRETCH_CYCLES - 1);
  localparam logic [GCW-1:0] G_TERM =
    GCW'(STAGE_GAP - 1);
  localparam logic [SKW-1:0] K_LAST =
    SKW'(NUM_DOMAINS - 1);

  logic ext_rstn_s;
  logic lock_s;
  logic good;

  seq_state_t state_q, state_d;

  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic [SCW-1:0]         scnt_q, scnt_d;
  logic [GCW-1:0]         gcnt_q, gcnt_d;
  logic [SKW-1:0]         stage_q, stage_d;
  logic                   ack_q, ack_d;

  logic s_term;
  logic g_term;

  sync_2ff u_sync_ext (
    .clk (pl_clk_100m),
    .rst (pl_rst),
    .d   (ext_rstn_in),
    .q   (ext_rstn_s)
  );

  sync_2ff u_sync_lock (
    .clk (pl_clk_100m),
    .rst (pl_rst),
    .d   (lock_in),
    .q   (lock_s)
  );

  assign good   = ext_rstn_s & lock_s;
  assign s_term = (scnt_q == S_TERM);
  assign g_term = (gcnt_q == G_TERM);

  always_ff @(posedge pl_clk_100m or posedge pl_rst) begin
    if (pl_rst) state_q <= HOLD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HOLD: begin
        if (good) state_d = STRETCH;
      end
      STRETCH: begin
        if (!good)
          state_d = HOLD;
        else if (s_term)
          state_d = (NUM_DOMAINS == 1) ? RUN : RELEASE;
      end
      RELEASE: begin
        if (!good)
          state_d = HOLD;
        else if (g_term && stage_q == K_LAST)
          state_d = RUN;
      end
      RUN: begin
        if (!good || sw_rst_req) state_d = HOLD;
      end
    endcase
  end

  // Any move into HOLD drops every domain at once.
  always_comb begin
    dom_d   = dom_q;
    scnt_d  = '0;
    gcnt_d  = '0;
    stage_d = stage_q;
    ack_d   = (state_q == RUN) && sw_rst_req;
    if (state_d == HOLD) begin
      dom_d   = '0;
      stage_d = SKW'(1);
    end else begin
      unique case (state_q)
        HOLD: begin
          stage_d = SKW'(1);
        end
        STRETCH: begin
          if (s_term) begin
            dom_d[0] = 1'b1;
            stage_d  = SKW'(1);
          end else begin
            scnt_d = scnt_q + SCW'(1);
          end
        end
        RELEASE: begin
          if (g_term) begin
            for (int i = 0; i < NUM_DOMAINS; i++)
              if (stage_q == SKW'(i)) dom_d[i] = 1'b1;
            stage_d = stage_q + SKW'(1);
          end else begin
            gcnt_d = gcnt_q + GCW'(1);
          end
        end
        RUN: begin
          dom_d = '1;
        end
      endcase
    end
  end

  always_ff @(posedge pl_clk_100m or posedge pl_rst) begin
    if (pl_rst) begin
      dom_q   <= '0;
      scnt_q  <= '0;
      gcnt_q  <= '0;
      stage_q <= SKW'(1);
      ack_q   <= 1'b0;
    end else begin
      dom_q   <= dom_d;
      scnt_q  <= scnt_d;
      gcnt_q  <= gcnt_d;
      stage_q <= stage_d;
      ack_q   <= ack_d;
    end
  end

  assign dom_rstn   = dom_q;
  assign sw_rst_ack = ack_q;
  assign seq_done   = (state_q == RUN);
  assign seq_state  = state_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: expected output
// events queued by stimulus, checked by monitor.
module tb_rst_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       ext_rstn_in;
  logic       lock_in;
  logic       sw_rst_req;
  logic       sw_rst_ack;
  logic [3:0] dom_rstn;
  logic       seq_done;
  logic [1:0] seq_state;

  typedef struct {
    int         cyc;
    logic [3:0] dom;
    logic       done;
    logic       ack;
    logic [1:0] st;
  } ev_t;

  ev_t exp_q[$];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  logic [7:0] prev = '0;

  rst_seq_ctrl #(
    .NUM_DOMAINS    (4),
    .STRETCH_CYCLES (16),
    .STAGE_GAP      (8)
  ) dut (
    .pl_clk_100m (clk),
    .pl_rst      (rst),
    .ext_rstn_in (ext_rstn_in),
    .lock_in     (lock_in),
    .sw_rst_req  (sw_rst_req),
    .sw_rst_ack  (sw_rst_ack),
    .dom_rstn    (dom_rstn),
    .seq_done    (seq_done),
    .seq_state   (seq_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [3:0] d,
                      input logic dn, input logic a,
                      input logic [1:0] s);
    ev_t e;
    e.cyc  = c;
    e.dom  = d;
    e.done = dn;
    e.ack  = a;
    e.st   = s;
    exp_q.push_back(e);
  endtask

  task automatic wait_edge(input int abs_cyc);
    while (cyc < abs_cyc) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_seq(input int s);
    push(s,      4'b0000, 1'b0, 1'b0, 2'd1);
    push(s + 16, 4'b0001, 1'b0, 1'b0, 2'd2);
    push(s + 24, 4'b0011, 1'b0, 1'b0, 2'd2);
    push(s + 32, 4'b0111, 1'b0, 1'b0, 2'd2);
    push(s + 40, 4'b1111, 1'b1, 1'b0, 2'd3);
  endtask

  always @(negedge clk) begin
    logic [7:0] cur;
    ev_t e;
    cur = {dom_rstn, seq_done, sw_rst_ack, seq_state};
    if (cur !== prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d got=%b",
                 cyc, cur);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc ||
            cur !== {e.dom, e.done, e.ack, e.st}) begin
          errors++;
          $display("FAIL event cyc=%0d got=%b exp cyc=%0d val=%b",
                   cyc, cur, e.cyc,
                   {e.dom, e.done, e.ack, e.st});
        end
      end
      prev = cur;
    end
  end

  initial begin
    #30000;
    errors++;
    $display("FAIL watchdog cyc=%0d pending=%0d",
             cyc, exp_q.size());
    $display("Result: errors=%0d of %0d checks",
             errors, checks + 1);
    $fatal(1);
  end

  initial begin
    int b, n, r1, r2, e, f, g, h;
    rst         = 1'b0;
    ext_rstn_in = 1'b1;
    lock_in     = 1'b1;
    sw_rst_req  = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({dom_rstn, seq_done, sw_rst_ack, seq_state} !== 8'h00) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b",
               {dom_rstn, seq_done, sw_rst_ack, seq_state},
               8'h00);
    end

    // power-up sequence
    wait_edge(2);
    rst = 1'b0;
    b = 2;
    push_seq(b + 3);

    // software reset in RUN
    r1 = b + 43;
    n  = r1 + 3;
    push(n,     4'b0000, 1'b0, 1'b1, 2'd0);
    push(n + 1, 4'b0000, 1'b0, 1'b0, 2'd1);
    push(n + 17, 4'b0001, 1'b0, 1'b0, 2'd2);
    push(n + 25, 4'b0011, 1'b0, 1'b0, 2'd2);
    push(n + 33, 4'b0111, 1'b0, 1'b0, 2'd2);
    push(n + 41, 4'b1111, 1'b1, 1'b0, 2'd3);
    wait_edge(r1 + 2);
    sw_rst_req = 1'b1;
    wait_edge(n);
    sw_rst_req = 1'b0;

    // ignored requests in STRETCH and RELEASE
    wait_edge(n + 4);
    sw_rst_req = 1'b1;
    wait_edge(n + 5);
    sw_rst_req = 1'b0;
    wait_edge(n + 19);
    sw_rst_req = 1'b1;
    wait_edge(n + 20);
    sw_rst_req = 1'b0;

    // request together with lock loss in RUN
    r2 = n + 41;
    push(r2 + 5,  4'b0000, 1'b0, 1'b1, 2'd0);
    push(r2 + 6,  4'b0000, 1'b0, 1'b0, 2'd0);
    push(r2 + 10, 4'b0000, 1'b0, 1'b0, 2'd1);
    wait_edge(r2 + 2);
    lock_in = 1'b0;
    wait_edge(r2 + 4);
    sw_rst_req = 1'b1;
    wait_edge(r2 + 5);
    sw_rst_req = 1'b0;
    wait_edge(r2 + 7);
    lock_in = 1'b1;

    // lock loss mid-STRETCH at count 10
    e = r2 + 10;
    f = e + 16;
    push(e + 11, 4'b0000, 1'b0, 1'b0, 2'd0);
    push(f,      4'b0000, 1'b0, 1'b0, 2'd1);
    push(f + 16, 4'b0001, 1'b0, 1'b0, 2'd2);
    push(f + 24, 4'b0011, 1'b0, 1'b0, 2'd2);
    wait_edge(e + 8);
    lock_in = 1'b0;
    wait_edge(e + 13);
    lock_in = 1'b1;

    // ext reset loss in RELEASE at 0011
    g = f + 33;
    push(f + 28, 4'b0000, 1'b0, 1'b0, 2'd0);
    push_seq(g);
    wait_edge(f + 25);
    ext_rstn_in = 1'b0;
    wait_edge(f + 30);
    ext_rstn_in = 1'b1;

    // async pl_rst mid-RUN
    h = g + 40;
    push(h + 3, 4'b0000, 1'b0, 1'b0, 2'd0);
    wait_edge(h + 3);
    rst = 1'b1;
    #1;
    checks++;
    if (dom_rstn !== 4'b0000 || seq_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset dom=%b done=%b exp dom=0000 done=0",
               dom_rstn, seq_done);
    end
    wait_edge(h + 5);
    rst = 1'b0;
    b = h + 5;
    push_seq(b + 3);

    wait_edge(b + 50);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events pending=%0d exp=0 next_cyc=%0d",
               exp_q.size(), exp_q[0].cyc);
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
